// File: rtl/harness_sequencer_if.sv
// Command/response handshake bundle between a host and the harness sequencer.
interface harness_sequencer_if;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_ready;

  // Host side: issues command bytes and consumes response words.
  modport master (
    output cmd_data, cmd_valid, resp_ready,
    input  cmd_ready, resp_data, resp_valid
  );

  // Sequencer side: accepts command bytes and produces response words.
  modport slave (
    input  cmd_data, cmd_valid, resp_ready,
    output cmd_ready, resp_data, resp_valid
  );
endinterface

// File: rtl/harness_sequencer.sv
// Byte-command sequencer that drives a DUT: loads inputs, steps it, controls
// its reset and streams back snapshots of its outputs as 32-bit words.
module harness_sequencer #(
  parameter int IN_BYTES  = 4,
  parameter int OUT_WORDS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  harness_sequencer_if.slave        bus,
  output logic [IN_BYTES*8-1:0]     dut_in,
  input  logic [OUT_WORDS*32-1:0]   dut_out,
  output logic                      dut_rst,
  output logic                      dut_step,
  output logic                      done,
  output logic                      error
);

  localparam int CNT_W = (IN_BYTES  > 1) ? $clog2(IN_BYTES)  : 1;
  localparam int IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  localparam logic [7:0] CMD_SEND  = 8'd104;
  localparam logic [7:0] CMD_HALT  = 8'd105;
  localparam logic [7:0] CMD_RSTHI = 8'd106;
  localparam logic [7:0] CMD_RSTLO = 8'd107;
  localparam logic [7:0] CMD_STEP  = 8'd108;
  localparam logic [7:0] CMD_LOAD  = 8'd109;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_SEND,
    S_HALT,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [IN_BYTES*8-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IN_BYTES*8-1:0]   dut_in_q, dut_in_d;
  logic                    dut_rst_q, dut_rst_d;
  logic [OUT_WORDS*32-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    dut_step_q, dut_step_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_data_q, resp_data_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic cmd_accept;
  logic resp_accept;

  assign cmd_accept  = bus.cmd_valid & cmd_ready_q;
  assign resp_accept = resp_valid_q & bus.resp_ready;

  // Next-state and datapath decode; outputs are derived from the next state so
  // every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in_q;
    dut_rst_d  = dut_rst_q;
    snap_d     = snap_q;
    idx_d      = idx_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          case (bus.cmd_data)
            CMD_SEND: begin
              snap_d  = dut_out;
              idx_d   = '0;
              state_d = S_SEND;
            end
            CMD_HALT:  state_d   = S_HALT;
            CMD_RSTHI: dut_rst_d = 1'b1;
            CMD_RSTLO: dut_rst_d = 1'b0;
            CMD_STEP:  state_d   = S_STEP;
            CMD_LOAD: begin
              cnt_d   = '0;
              state_d = S_LOAD;
            end
            default:   state_d   = S_ERR;
          endcase
        end
      end

      S_LOAD: begin
        if (cmd_accept) begin
          shadow_d = shadow_q >> 8;
          shadow_d[IN_BYTES*8-1 -: 8] = bus.cmd_data;
          if (cnt_q == CNT_W'(IN_BYTES - 1)) begin
            dut_in_d = shadow_d;
            cnt_d    = '0;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_STEP: state_d = S_IDLE;

      S_SEND: begin
        if (resp_accept) begin
          if (idx_q == IDX_W'(OUT_WORDS - 1)) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    cmd_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    dut_step_d   = (state_d == S_STEP);
    resp_valid_d = (state_d == S_SEND);
    done_d       = (state_d == S_HALT) || (state_d == S_ERR);
    error_d      = (state_d == S_ERR);

    resp_data_d = resp_data_q;
    for (int w = 0; w < OUT_WORDS; w++) begin
      if (idx_d == IDX_W'(w)) resp_data_d = snap_d[w*32 +: 32];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      cnt_q        <= '0;
      dut_in_q     <= '0;
      dut_rst_q    <= 1'b1;
      snap_q       <= '0;
      idx_q        <= '0;
      cmd_ready_q  <= 1'b0;
      dut_step_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      dut_in_q     <= dut_in_d;
      dut_rst_q    <= dut_rst_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      cmd_ready_q  <= cmd_ready_d;
      dut_step_q   <= dut_step_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign dut_in         = dut_in_q;
  assign dut_rst        = dut_rst_q;
  assign dut_step       = dut_step_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_harness_sequencer.sv
// Self-checking bench for harness_sequencer with IN_BYTES=4, OUT_WORDS=2.
module tb_harness_sequencer;

  localparam int IN_BYTES  = 4;
  localparam int OUT_WORDS = 2;

  logic                    clk;
  logic                    rst;
  logic [IN_BYTES*8-1:0]   dut_in;
  logic [OUT_WORDS*32-1:0] dut_out;
  logic                    dut_rst;
  logic                    dut_step;
  logic                    done;
  logic                    error;

  harness_sequencer_if bus ();

  harness_sequencer #(
    .IN_BYTES  (IN_BYTES),
    .OUT_WORDS (OUT_WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .dut_rst  (dut_rst),
    .dut_step (dut_step),
    .done     (done),
    .error    (error)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference state: what the sequencer should be showing, from the command rules.
  logic [IN_BYTES*8-1:0] exp_dut_in;
  logic                  exp_dut_rst;

  // Compare helper values are inlined in each task; this just tallies.
  // Every task starts and ends just after a falling edge.

  task automatic do_reset();
    rst = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_dut_in  = '0;
    exp_dut_rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout byte=%0d cmd_ready=%b required=1", b, bus.cmd_ready);
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic check_holds(input string name);
    checks++;
    if (dut_in !== exp_dut_in || dut_rst !== exp_dut_rst) begin
      failures++;
      $display("[TB] FAIL %s dut_in=%h dut_rst=%b required dut_in=%h dut_rst=%b",
               name, dut_in, dut_rst, exp_dut_in, exp_dut_rst);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = 8'h00;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, dut_in, dut_rst, dut_step, bus.resp_valid, bus.resp_data, done, error}
        !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state rdy=%b in=%h rst=%b step=%b rv=%b rd=%h done=%b err=%b required 0,0,1,0,0,0,0,0",
               bus.cmd_ready, dut_in, dut_rst, dut_step, bus.resp_valid, bus.resp_data, done, error);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset cmd_ready=%b required=1", bus.cmd_ready);
    end
    exp_dut_in  = '0;
    exp_dut_rst = 1'b1;
  endtask

  task automatic test_step();
    int highs;
    send_byte(8'd107);
    exp_dut_rst = 1'b0;
    checks++;
    if (dut_rst !== 1'b0) begin
      failures++;
      $display("[TB] FAIL k_clears_dut_rst dut_rst=%b required=0", dut_rst);
    end
    send_byte(8'd108);
    checks++;
    if (dut_step !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL step_cycle dut_step=%b cmd_ready=%b required 1,0", dut_step, bus.cmd_ready);
    end
    highs = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dut_step === 1'b1) highs++;
    end
    checks++;
    if (highs != 1 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL step_pulse_width high_cycles=%0d cmd_ready=%b required 1,1", highs, bus.cmd_ready);
    end
    check_holds("step_holds");
  endtask

  task automatic test_load();
    logic [7:0] bytes_in [4];
    bytes_in[0] = 8'h11; bytes_in[1] = 8'h22; bytes_in[2] = 8'h68; bytes_in[3] = 8'h44;
    send_byte(8'd109);
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes_in[i]);
      checks++;
      if (dut_in !== exp_dut_in || bus.resp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL load_partial_%0d dut_in=%h rv=%b rdy=%b required %h,0,1",
                 i, dut_in, bus.resp_valid, bus.cmd_ready, exp_dut_in);
      end
    end
    send_byte(bytes_in[3]);
    exp_dut_in = 32'h44682211;
    checks++;
    if (dut_in !== 32'h44682211) begin
      failures++;
      $display("[TB] FAIL load_complete dut_in=%h required=44682211", dut_in);
    end
  endtask

  task automatic test_send();
    dut_out = {32'hBBBBBBBB, 32'hAAAAAAAA};
    bus.resp_ready = 1'b0;
    send_byte(8'd104);
    for (int i = 0; i < 5; i++) begin
      dut_out = {$urandom, $urandom};
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hAAAAAAAA) begin
        failures++;
        $display("[TB] FAIL send_stall_%0d rv=%b data=%h required 1,aaaaaaaa", i, bus.resp_valid, bus.resp_data);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hAAAAAAAA) begin
      failures++;
      $display("[TB] FAIL send_word0 rv=%b data=%h required 1,aaaaaaaa", bus.resp_valid, bus.resp_data);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hBBBBBBBB) begin
      failures++;
      $display("[TB] FAIL send_word1 rv=%b data=%h required 1,bbbbbbbb", bus.resp_valid, bus.resp_data);
    end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL send_back_to_idle rv=%b rdy=%b required 0,1", bus.resp_valid, bus.cmd_ready);
    end
    check_holds("send_holds");
  endtask

  // Random command mix against the model: dut_rst toggles, steps, loads with
  // arbitrary payload bytes, and snapshots read back with random stalls.
  task automatic test_random();
    logic [7:0]  pl [IN_BYTES];
    logic [31:0] words [OUT_WORDS];
    for (int op = 0; op < 60; op++) begin
      case ($urandom_range(0, 4))
        0: begin send_byte(8'd106); exp_dut_rst = 1'b1; check_holds("rand_j"); end
        1: begin send_byte(8'd107); exp_dut_rst = 1'b0; check_holds("rand_k"); end
        2: begin
          send_byte(8'd108);
          checks++;
          if (dut_step !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rand_step dut_step=%b required=1", dut_step);
          end
          @(negedge clk);
        end
        3: begin
          send_byte(8'd109);
          for (int i = 0; i < IN_BYTES; i++) begin
            pl[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) pl[i] = 8'($urandom_range(104, 111));
            send_byte(pl[i]);
            if (i < IN_BYTES - 1) check_holds("rand_load_partial");
          end
          for (int i = 0; i < IN_BYTES; i++) exp_dut_in[8*i +: 8] = pl[i];
          check_holds("rand_load_done");
        end
        default: begin
          for (int w = 0; w < OUT_WORDS; w++) words[w] = $urandom;
          for (int w = 0; w < OUT_WORDS; w++) dut_out[32*w +: 32] = words[w];
          send_byte(8'd104);
          for (int w = 0; w < OUT_WORDS; w++) begin
            bus.resp_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
              dut_out = {$urandom, $urandom};
              @(negedge clk);
            end
            bus.resp_ready = 1'b1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== words[w]) begin
              failures++;
              $display("[TB] FAIL rand_word%0d rv=%b data=%h required 1,%h", w, bus.resp_valid, bus.resp_data, words[w]);
            end
            @(negedge clk);
          end
          bus.resp_ready = 1'b0;
          checks++;
          if (bus.resp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rand_send_end rv=%b rdy=%b required 0,1", bus.resp_valid, bus.cmd_ready);
          end
        end
      endcase
    end
  endtask

  task automatic test_halt();
    send_byte(8'd105);
    checks++;
    if (done !== 1'b1 || bus.cmd_ready !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_state done=%b rdy=%b err=%b required 1,0,0", done, bus.cmd_ready, error);
    end
    bus.cmd_data  = (exp_dut_rst) ? 8'd107 : 8'd106;
    bus.cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_sticky done=%b rdy=%b required 1,0", done, bus.cmd_ready);
    end
    check_holds("halt_holds");
    do_reset();
  endtask

  task automatic test_error();
    logic [7:0] bad;
    do bad = 8'($urandom_range(0, 255)); while (bad >= 8'd104 && bad <= 8'd109);
    send_byte(bad);
    checks++;
    if (error !== 1'b1 || done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL error_state byte=%0d err=%b done=%b rdy=%b required 1,1,0", bad, error, done, bus.cmd_ready);
    end
    bus.cmd_data  = 8'd107;
    bus.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_holds("error_ignores_bytes");
    do_reset();
    checks++;
    if (error !== 1'b0 || done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL error_cleared err=%b done=%b rdy=%b required 0,0,1", error, done, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] pl [IN_BYTES];
    send_byte(8'd109);
    send_byte(8'h01);
    send_byte(8'h02);
    do_reset();
    check_holds("abort_load_cleared");
    send_byte(8'd109);
    for (int i = 0; i < IN_BYTES; i++) begin
      pl[i] = 8'($urandom_range(0, 255));
      send_byte(pl[i]);
    end
    for (int i = 0; i < IN_BYTES; i++) exp_dut_in[8*i +: 8] = pl[i];
    check_holds("reload_after_abort");
    dut_out = {$urandom, $urandom};
    bus.resp_ready = 1'b0;
    send_byte(8'd104);
    do_reset();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_send rv=%b data=%h rdy=%b required 0,0,1", bus.resp_valid, bus.resp_data, bus.cmd_ready);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    dut_out     = '0;
    bus.cmd_data   = 8'h00;
    bus.cmd_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    exp_dut_in  = '0;
    exp_dut_rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_step();
    test_load();
    test_send();
    test_random();
    test_halt();
    test_error();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
